sha256_host_ctrl: RTL and testbench

Host-side controller on the far end of the `simplified_sha256` memory interface.
- Accepts a message as a stream of 32-bit words and writes it into the shared word memory at `msg_addr`.
- Pulses `hash_start` to the hasher and waits for the hasher to finish.
- Reads the 8-word digest back from `digest_addr` and emits it as an output stream.
- Owns the memory port whenever the hasher is not running; the top level uses `mem_sel` to mux the port.

---
 rtl/sha256_host_pkg.sv | 20 ++
 rtl/sha256_digest_buf.sv | 26 ++
 rtl/sha256_host_ctrl.sv | 144 ++++++++++++++
 tb/tb_sha256_host_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_host_pkg.sv
// Shared types and constants for the SHA-256 host controller slice.
package sha256_host_pkg;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 32;
  localparam int DIGEST_WORDS = 8;
  localparam int READ_LATENCY = 1;
  localparam int IDX_W        = $clog2(DIGEST_WORDS);

  typedef enum logic [2:0] {
    ST_FILL,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_READ,
    ST_DRAIN,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/sha256_digest_buf.sv
// Eight-word digest holding buffer: filled during READ, indexed by the DRAIN pointer.
module sha256_digest_buf
  import sha256_host_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] regs [DIGEST_WORDS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DIGEST_WORDS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

  assign rd_data = regs[rd_idx];

endmodule

// File: rtl/sha256_host_ctrl.sv
// Host-side controller: writes a message into shared memory, starts the hasher,
// waits for it, then reads the digest back and streams it out.
module sha256_host_ctrl
  import sha256_host_pkg::*;
#(
  parameter int NUM_OF_WORDS   = 20,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] msg_addr,
  input  logic [ADDR_W-1:0] digest_addr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              hash_start,
  input  logic              hash_done,
  output logic [ADDR_W-1:0] hash_message_addr,
  output logic [ADDR_W-1:0] hash_output_addr,
  output logic              mem_sel,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy,
  output logic              error
);

  localparam int                 TMO_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [7:0]         LAST_WORD = 8'(NUM_OF_WORDS - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]         ISSUE_END = 4'(DIGEST_WORDS);
  localparam logic [3:0]         CAP_FIRST = 4'(READ_LATENCY + 1);
  localparam logic [3:0]         READ_LAST = 4'(DIGEST_WORDS + READ_LATENCY);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(DIGEST_WORDS - 1);

  state_t            state, state_next;
  logic [7:0]        count;
  logic [ADDR_W-1:0] msg_base, dig_base, fill_addr;
  logic [3:0]        rd_cnt;
  logic [IDX_W-1:0]  idx, buf_widx;
  logic [TMO_W-1:0]  tmo;
  logic              accept, last_word, timed_out, buf_we;
  logic [DATA_W-1:0] buf_rdata;

  assign accept            = in_valid && in_ready;
  assign last_word         = (count == LAST_WORD);
  assign timed_out         = (tmo == TMO_LAST);
  assign fill_addr         = ((count == 8'd0) ? msg_addr : msg_base) + ADDR_W'(count);
  assign hash_message_addr = msg_base;
  assign hash_output_addr  = dig_base;

  // State register plus the registered memory request and job bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_FILL;
      in_ready       <= 1'b0;
      count          <= '0;
      msg_base       <= '0;
      dig_base       <= '0;
      mem_sel        <= 1'b1;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      rd_cnt         <= '0;
      idx            <= '0;
      tmo            <= '0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next == ST_FILL);
      mem_we   <= 1'b0;
      case (state)
        ST_FILL: if (accept) begin
          mem_we         <= 1'b1;
          mem_addr       <= fill_addr;
          mem_write_data <= in_data;
          count          <= last_word ? 8'd0 : count + 8'd1;
          if (count == 8'd0) begin
            msg_base <= msg_addr;
            dig_base <= digest_addr;
          end
        end
        ST_LAUNCH: begin
          mem_sel <= 1'b0;
          tmo     <= '0;
        end
        ST_WAIT_BUSY, ST_WAIT_DONE: begin
          tmo    <= tmo + TMO_W'(1);
          rd_cnt <= '0;
          if (state_next == ST_READ || state_next == ST_ERROR) mem_sel <= 1'b1;
        end
        ST_READ: begin
          rd_cnt <= rd_cnt + 4'd1;
          idx    <= '0;
          if (rd_cnt < ISSUE_END) mem_addr <= dig_base + ADDR_W'(rd_cnt);
        end
        ST_DRAIN: if (out_ready) idx <= idx + IDX_W'(1);
        default: mem_sel <= 1'b1;
      endcase
    end
  end

  // A done level seen before the hasher has ever dropped it is not completion.
  always_comb begin
    state_next = state;
    case (state)
      ST_FILL:      if (accept && last_word) state_next = ST_LAUNCH;
      ST_LAUNCH:    state_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (!hash_done) state_next = ST_WAIT_DONE;
                    else if (timed_out) state_next = ST_ERROR;
      ST_WAIT_DONE: if (hash_done) state_next = ST_READ;
                    else if (timed_out) state_next = ST_ERROR;
      ST_READ:      if (rd_cnt == READ_LAST) state_next = ST_DRAIN;
      ST_DRAIN:     if (out_ready && out_last) state_next = ST_FILL;
      default:      state_next = ST_ERROR;
    endcase
  end

  always_comb begin
    hash_start = (state == ST_LAUNCH);
    busy       = (state != ST_FILL) || (count != 8'd0);
    error      = (state == ST_ERROR);
    out_valid  = (state == ST_DRAIN);
    out_last   = out_valid && (idx == LAST_IDX);
    out_data   = out_valid ? buf_rdata : '0;
    buf_we     = (state == ST_READ) && (rd_cnt >= CAP_FIRST);
    buf_widx   = IDX_W'(rd_cnt - CAP_FIRST);
  end

  sha256_digest_buf u_digest_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (buf_we),
    .wr_idx  (buf_widx),
    .wr_data (mem_read_data),
    .rd_idx  (idx),
    .rd_data (buf_rdata)
  );

endmodule

// File: tb/tb_sha256_host_ctrl.sv
// Directed bench for sha256_host_ctrl with a shared word memory, a 2:1 port mux
// and a scripted hasher stub.
module tb_sha256_host_ctrl;

  localparam int NWORDS = 20;

  logic        clk;
  logic        reset_n;
  logic [15:0] msg_addr, digest_addr;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_last, out_ready;
  logic [31:0] out_data;
  logic        hash_start, hash_done;
  logic [15:0] hash_message_addr, hash_output_addr;
  logic        mem_sel, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;
  logic        busy, error;

  logic        stub_we;
  logic [15:0] stub_addr;
  logic [31:0] stub_wdata;
  logic        m_we;
  logic [15:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] mem [0:65535];

  int n_checks = 0;
  int n_pass   = 0;

  sha256_host_ctrl #(.NUM_OF_WORDS(NWORDS), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .msg_addr(msg_addr), .digest_addr(digest_addr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .hash_start(hash_start), .hash_done(hash_done),
    .hash_message_addr(hash_message_addr), .hash_output_addr(hash_output_addr),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .busy(busy), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Top-level port mux and the shared synchronous word memory.
  assign m_we    = mem_sel ? mem_we : stub_we;
  assign m_addr  = mem_sel ? mem_addr : stub_addr;
  assign m_wdata = mem_sel ? mem_write_data : stub_wdata;

  always @(posedge clk) begin
    if (m_we) mem[m_addr] <= m_wdata;
    mem_read_data <= mem[m_addr];
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_message(input logic [15:0] ma, input logic [15:0] da, input logic [31:0] first);
    for (int i = 0; i < NWORDS; i++) begin
      in_valid    = 1'b1;
      in_data     = first + 32'(i);
      msg_addr    = ma;
      digest_addr = da;
      tick();
    end
    in_valid    = 1'b0;
    msg_addr    = 16'hAAAA;
    digest_addr = 16'hBBBB;
  endtask

  // Hasher stub: drop done, write eight digest words, raise done, then idle with we held high.
  task automatic hasher_run(input logic [15:0] da, input logic [31:0] vbase);
    hash_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      stub_we    = 1'b1;
      stub_addr  = da + 16'(k);
      stub_wdata = vbase + 32'(k);
      tick();
    end
    hash_done = 1'b1;
    tick();
    stub_addr  = da;
    stub_wdata = 32'hDEADBEEF;
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({in_ready, mem_sel, mem_we, hash_start, busy, error, out_valid, out_last} !== 8'b0100_0000)
      $display("[TB] FAIL reset_ctrl: got %b expected 01000000",
               {in_ready, mem_sel, mem_we, hash_start, busy, error, out_valid, out_last});
    else n_pass++;
    n_checks++;
    if ({mem_addr, mem_write_data, out_data, hash_message_addr, hash_output_addr} !== 112'h0)
      $display("[TB] FAIL reset_data: got %h expected 0",
               {mem_addr, mem_write_data, out_data, hash_message_addr, hash_output_addr});
    else n_pass++;
    reset_n = 1'b1;
    n_checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL in_ready_before_edge: got %b expected 0", in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if ({in_ready, mem_sel, busy} !== 3'b110)
      $display("[TB] FAIL in_ready_after_release: got %b expected 110", {in_ready, mem_sel, busy});
    else n_pass++;
  endtask

  task automatic test_basic_job();
    int early, bad;
    early = 0;
    bad   = 0;
    for (int i = 0; i < NWORDS; i++) begin
      in_valid    = 1'b1;
      in_data     = 32'(i + 1);
      msg_addr    = (i == 0) ? 16'h0000 : 16'h5555;
      digest_addr = (i == 0) ? 16'h0100 : 16'h7777;
      tick();
      if (hash_start !== 1'b0 && i < NWORDS - 1) early++;
      if (i == 0) begin
        n_checks++;
        if ({mem_we, mem_addr, mem_write_data, busy} !== {1'b1, 16'h0000, 32'h1, 1'b1})
          $display("[TB] FAIL first_write: got %h expected %h",
                   {mem_we, mem_addr, mem_write_data, busy}, {1'b1, 16'h0000, 32'h1, 1'b1});
        else n_pass++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if ({hash_start, in_ready, mem_we, mem_addr, mem_write_data} !== {3'b101, 16'h0013, 32'h14})
      $display("[TB] FAIL launch_cycle: got %h expected %h",
               {hash_start, in_ready, mem_we, mem_addr, mem_write_data}, {3'b101, 16'h0013, 32'h14});
    else n_pass++;
    n_checks++;
    if ({hash_message_addr, hash_output_addr} !== {16'h0000, 16'h0100})
      $display("[TB] FAIL latched_addrs: got %h expected 00000100", {hash_message_addr, hash_output_addr});
    else n_pass++;
    n_checks++;
    if (early !== 0) $display("[TB] FAIL start_early: got %0d expected 0", early);
    else n_pass++;
    tick();
    n_checks++;
    if ({hash_start, mem_sel, mem_we} !== 3'b000)
      $display("[TB] FAIL start_one_cycle: got %b expected 000", {hash_start, mem_sel, mem_we});
    else n_pass++;
    for (int k = 0; k < NWORDS; k++) if (mem[k] !== 32'(k + 1)) bad++;
    n_checks++;
    if (bad !== 0) $display("[TB] FAIL msg_memory: got %0d bad words expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_digest_readback();
    int lat;
    hasher_run(16'h0100, 32'hA0000000);
    n_checks++;
    if (mem_sel !== 1'b1) $display("[TB] FAIL read_mem_sel: got %b expected 1", mem_sel);
    else n_pass++;
    out_ready = 1'b1;
    wait_out_valid(lat);
    n_checks++;
    if (lat !== 10) $display("[TB] FAIL digest_latency: got %0d expected 10", lat);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if ({out_valid, out_data, out_last} !== {1'b1, 32'hA0000000 + 32'(k), k == 7})
        $display("[TB] FAIL digest_word%0d: got %h expected %h", k,
                 {out_valid, out_data, out_last}, {1'b1, 32'hA0000000 + 32'(k), k == 7});
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({out_valid, busy, in_ready} !== 3'b001)
      $display("[TB] FAIL back_to_fill: got %b expected 001", {out_valid, busy, in_ready});
    else n_pass++;
  endtask

  task automatic test_stale_done();
    int bad, lat, nwords;
    bad    = 0;
    nwords = 0;
    send_message(16'h0020, 16'h0180, 32'h00000100);
    tick();
    for (int s = 0; s < 5; s++) begin
      if ({mem_sel, mem_we, out_valid, hash_start, busy} !== 5'b00001) bad++;
      tick();
    end
    n_checks++;
    if (bad !== 0) $display("[TB] FAIL stale_done_wait: got %0d bad cycles expected 0", bad);
    else n_pass++;
    hasher_run(16'h0180, 32'hC0000000);
    out_ready = 1'b1;
    wait_out_valid(lat);
    bad = 0;
    while (out_valid === 1'b1 && nwords < 12) begin
      if (out_data !== 32'hC0000000 + 32'(nwords)) bad++;
      nwords++;
      tick();
    end
    n_checks++;
    if ({bad, nwords} !== {32'd0, 32'd8})
      $display("[TB] FAIL stale_digest: got bad=%0d words=%0d expected bad=0 words=8", bad, nwords);
    else n_pass++;
    bad = 0;
    for (int k = 0; k < NWORDS; k++) if (mem[16'h0020 + 16'(k)] !== 32'h100 + 32'(k)) bad++;
    n_checks++;
    if (bad !== 0) $display("[TB] FAIL stale_msg_memory: got %0d bad words expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [3:0]  pattern;
    logic [32:0] held;
    int k, bad, unstable, lat;
    logic stalled;
    pattern  = 4'b1001;
    k        = 0;
    bad      = 0;
    unstable = 0;
    stalled  = 1'b0;
    held     = '0;
    send_message(16'h0040, 16'h01C0, 32'h00000200);
    tick();
    hasher_run(16'h01C0, 32'hB0000000);
    out_ready = 1'b0;
    wait_out_valid(lat);
    for (int c = 0; c < 64 && k < 8; c++) begin
      out_ready = pattern[3 - (c % 4)];
      if (stalled && {out_data, out_last} !== held) unstable++;
      if (out_valid === 1'b1 && out_ready) begin
        if ({out_data, out_last} !== {32'hB0000000 + 32'(k), k == 7}) bad++;
        k++;
        stalled = 1'b0;
      end else if (out_valid === 1'b1) begin
        held    = {out_data, out_last};
        stalled = 1'b1;
      end
      tick();
    end
    out_ready = 1'b1;
    n_checks++;
    if (k !== 8) $display("[TB] FAIL bp_word_count: got %0d expected 8", k);
    else n_pass++;
    n_checks++;
    if (bad !== 0) $display("[TB] FAIL bp_word_values: got %0d bad expected 0", bad);
    else n_pass++;
    n_checks++;
    if (unstable !== 0) $display("[TB] FAIL bp_stall_stable: got %0d changes expected 0", unstable);
    else n_pass++;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("[TB] FAIL bp_done: got %b expected 01", {out_valid, in_ready});
    else n_pass++;
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    send_message(16'h0300, 16'h0400, 32'h00000400);
    tick();
    repeat (15) tick();
    n_checks++;
    if (error !== 1'b0) $display("[TB] FAIL timeout_early: got %b expected 0", error);
    else n_pass++;
    tick();
    n_checks++;
    if ({error, in_ready, mem_sel, mem_we, out_valid, busy} !== 6'b101001)
      $display("[TB] FAIL timeout_error: got %b expected 101001",
               {error, in_ready, mem_sel, mem_we, out_valid, busy});
    else n_pass++;
    in_valid = 1'b1;
    in_data  = 32'h12345678;
    for (int c = 0; c < 8; c++) begin
      hash_done = (c >= 2 && c < 5) ? 1'b0 : 1'b1;
      tick();
      if ({error, in_ready, mem_we, out_valid} !== 4'b1000) bad++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad !== 0) $display("[TB] FAIL error_sticky: got %0d bad cycles expected 0", bad);
    else n_pass++;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    n_checks++;
    if ({error, in_ready, busy} !== 3'b010)
      $display("[TB] FAIL error_cleared: got %b expected 010", {error, in_ready, busy});
    else n_pass++;
  endtask

  task automatic test_wrap_reset();
    int bad;
    logic [15:0] a;
    bad = 0;
    send_message(16'hFFF0, 16'h0200, 32'h00000500);
    n_checks++;
    if ({mem_we, mem_addr, mem_write_data} !== {1'b1, 16'h0003, 32'h513})
      $display("[TB] FAIL wrap_last_write: got %h expected %h",
               {mem_we, mem_addr, mem_write_data}, {1'b1, 16'h0003, 32'h513});
    else n_pass++;
    tick();
    for (int k = 0; k < NWORDS; k++) begin
      a = 16'hFFF0 + 16'(k);
      if (mem[a] !== 32'h500 + 32'(k)) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("[TB] FAIL wrap_memory: got %0d bad words expected 0", bad);
    else n_pass++;
    n_checks++;
    if ({mem[0], mem[3]} !== {32'h510, 32'h513})
      $display("[TB] FAIL wrap_low_words: got %h expected 0000051000000513", {mem[0], mem[3]});
    else n_pass++;
    hasher_run(16'h0200, 32'hD0000000);
    repeat (3) tick();
    n_checks++;
    if ({mem_sel, mem_addr} !== {1'b1, 16'h0202})
      $display("[TB] FAIL read_issue: got %h expected 10202", {mem_sel, mem_addr});
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, mem_sel, mem_we, hash_start, busy, error, out_valid, out_last} !== 8'b0100_0000)
      $display("[TB] FAIL midjob_reset_ctrl: got %b expected 01000000",
               {in_ready, mem_sel, mem_we, hash_start, busy, error, out_valid, out_last});
    else n_pass++;
    n_checks++;
    if ({mem_addr, mem_write_data, out_data, hash_message_addr, hash_output_addr} !== 112'h0)
      $display("[TB] FAIL midjob_reset_data: got %h expected 0",
               {mem_addr, mem_write_data, out_data, hash_message_addr, hash_output_addr});
    else n_pass++;
    tick();
    reset_n = 1'b1;
    tick();
    n_checks++;
    if ({in_ready, busy, mem_sel} !== 3'b101)
      $display("[TB] FAIL midjob_release: got %b expected 101", {in_ready, busy, mem_sel});
    else n_pass++;
  endtask

  initial begin
    reset_n     = 1'b0;
    msg_addr    = '0;
    digest_addr = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    hash_done   = 1'b1;
    stub_we     = 1'b1;
    stub_addr   = 16'h0100;
    stub_wdata  = 32'hDEADBEEF;
    $display("[TB] starting sha256_host_ctrl bench");
    test_reset();
    test_basic_job();
    test_digest_readback();
    test_stale_done();
    test_backpressure();
    test_timeout();
    test_wrap_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
